// File: rtl/agu_nd_pkg.sv
// Shared types and defaults for the N-dimensional address generator (agu_nd).
// The optional stall counter is enabled by defining AGU_ND_STALL_CNT_EN.
`timescale 1ns/1ps
package agu_pkg;
  localparam int AGU_W   = 32;
  localparam int AGU_DIM = 2;

  typedef enum logic {
    AGU_IDLE = 1'b0,
    AGU_RUN  = 1'b1
  } agu_state_e;

  // Packed per-dimension descriptor (stride or count), dim 0 in the low slice.
  typedef logic [AGU_DIM-1:0][AGU_W-1:0] agu_desc_t;
endpackage

// File: rtl/agu_nd_if.sv
// Handshake and descriptor bundle between the sequencer/consumer side and agu_nd.
// The optional stall counter (AGU_ND_STALL_CNT_EN) is a separate port on agu_nd.
`timescale 1ns/1ps
interface agu_nd_if
  import agu_pkg::*;
#(
  parameter int W   = AGU_W,
  parameter int DIM = AGU_DIM
);
  logic                    start;
  logic                    stop;
  logic [W-1:0]            base;
  logic [DIM-1:0][W-1:0]   stride;
  logic [DIM-1:0][W-1:0]   count;
  logic                    ready;
  logic                    valid;
  logic [W-1:0]            addr;
  logic                    last;
  logic [DIM-1:0]          last_dim;
  logic                    busy;
  logic                    done;

  modport master (
    output start, stop, base, stride, count, ready,
    input  valid, addr, last, last_dim, busy, done
  );

  modport slave (
    input  start, stop, base, stride, count, ready,
    output valid, addr, last, last_dim, busy, done
  );
endinterface

// File: rtl/agu_nd_dim.sv
// One loop dimension of agu_nd: index counter plus offset accumulator.
// Wraps to zero on its final index and emits a carry to the next outer dimension.
`timescale 1ns/1ps
module agu_dim
  import agu_pkg::*;
#(
  parameter int W = AGU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] stride,
  input  logic [W-1:0] count,
  output logic         is_last,
  output logic         carry,
  output logic [W-1:0] off
);
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] off_q, off_d;

  // count arrives already normalised to >= 1 by the top level.
  assign is_last = (idx_q == (count - W'(1)));
  assign carry   = inc & is_last;
  assign off     = off_q;

  always_comb begin
    idx_d = idx_q;
    off_d = off_q;
    if (clr) begin
      idx_d = '0;
      off_d = '0;
    end else if (inc) begin
      if (is_last) begin
        idx_d = '0;
        off_d = '0;
      end else begin
        idx_d = idx_q + W'(1);
        off_d = off_q + stride;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      off_q <= '0;
    end else begin
      idx_q <= idx_d;
      off_q <= off_d;
    end
  end
endmodule

// File: rtl/agu_nd.sv
// N-dimensional address generation unit: nested loops with per-dim stride/count,
// valid/ready output stream. Define AGU_ND_STALL_CNT_EN to add the stall_cnt port.
`timescale 1ns/1ps
module agu_nd
  import agu_pkg::*;
#(
  parameter int W   = AGU_W,
  parameter int DIM = AGU_DIM
) (
  input  logic         clk,
  input  logic         rst_n,
  agu_nd_if.slave      bus
`ifdef AGU_ND_STALL_CNT_EN
  ,
  output logic [W-1:0] stall_cnt
`endif
);
  agu_state_e            state_q;
  logic                  valid_q;
  logic                  done_q;
  logic [W-1:0]          base_q, base_d;
  logic [DIM-1:0][W-1:0] stride_q, stride_d;
  logic [DIM-1:0][W-1:0] count_q, count_d;

  logic                  start_acc;
  logic                  fire;
  logic [DIM-1:0]        inc_w;
  logic [DIM-1:0]        is_last_w;
  logic [DIM-1:0]        carry_w;
  logic [DIM-1:0]        last_dim_w;
  logic [DIM-1:0][W-1:0] off_w;
  logic [DIM-1:0][W-1:0] sum_w;

  assign start_acc = (state_q == AGU_IDLE) & bus.start;
  assign fire      = valid_q & bus.ready;

  always_comb begin
    base_d   = base_q;
    stride_d = stride_q;
    count_d  = count_q;
    if (start_acc) begin
      base_d   = bus.base;
      stride_d = bus.stride;
      for (int d = 0; d < DIM; d++) begin
        count_d[d] = (bus.count[d] == '0) ? W'(1) : bus.count[d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q   <= '0;
      stride_q <= '0;
      count_q  <= '0;
    end else begin
      base_q   <= base_d;
      stride_q <= stride_d;
      count_q  <= count_d;
    end
  end

  // Carry ripples outward: dim d advances only when every inner dim wraps.
  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_dim
      if (gi == 0) begin : g_inner
        assign inc_w[gi]      = fire;
        assign last_dim_w[gi] = is_last_w[gi];
        assign sum_w[gi]      = off_w[gi];
      end else begin : g_outer
        assign inc_w[gi]      = carry_w[gi-1];
        assign last_dim_w[gi] = last_dim_w[gi-1] & is_last_w[gi];
        assign sum_w[gi]      = sum_w[gi-1] + off_w[gi];
      end

      agu_dim #(.W(W)) u_dim (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_acc),
        .inc     (inc_w[gi]),
        .stride  (stride_q[gi]),
        .count   (count_q[gi]),
        .is_last (is_last_w[gi]),
        .carry   (carry_w[gi]),
        .off     (off_w[gi])
      );
    end
  endgenerate

  // A carry out of the outermost dim is exactly the fire of the final beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= AGU_IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        AGU_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= AGU_RUN;
            valid_q <= 1'b1;
          end
        end
        AGU_RUN: begin
          if (carry_w[DIM-1] | bus.stop) begin
            state_q <= AGU_IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= AGU_IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q == AGU_RUN);
  assign bus.done     = done_q;
  assign bus.addr     = base_q + sum_w[DIM-1];
  assign bus.last_dim = last_dim_w & {DIM{valid_q}};
  assign bus.last     = last_dim_w[DIM-1] & valid_q;

`ifdef AGU_ND_STALL_CNT_EN
  logic [W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (valid_q & ~bus.ready & (stall_q != '1)) begin
      stall_d = stall_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: doc/agu_nd.md
# agu_nd

Parametrised N-dimensional address generation unit and successor to the single-loop AGU. Produces a stream of addresses for up to `DIM` nested loops, each loop with its own stride and trip count, over a valid/ready handshake. It sits between the HPU sequencer, which issues `start` with the loop descriptors, and memory-request or datapath consumers, which apply backpressure through `ready`.

## Interface
Parameters:
- `W`, 32, address/stride/count width
- `DIM`, 2, number of nested loop dimensions (≥1); dim 0 is innermost

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `start`  in  1  launch a sequence; honoured only in IDLE
- `stop`  in  1  abort a running sequence
- `base`  in  W  start address; sampled at start
- `stride`  in  DIM×W  per-dim address increment, packed `[DIM-1:0][W-1:0]`; sampled at start
- `count`  in  DIM×W  per-dim trip count, same packing; sampled at start; 0 treated as 1
- `ready`  in  1  consumer accepts beat
- `valid`  out  1  `addr` is valid
- `addr`  out  W  current address
- `last`  out  1  current beat is the final beat of the sequence
- `last_dim`  out  DIM  bit d set when dims 0..d are all at their final index
- `busy`  out  1  state is RUN
- `done`  out  1  one-cycle pulse after the final beat or after an abort
- `stall_cnt`  out  W  present only with `AGU_ND_STALL_CNT_EN`

## Operation
- States: IDLE and RUN.
- IDLE -> RUN on `start`. Latch `base`, `stride`, `count`. Clear all index and offset registers.
- In RUN, `valid` is 1. A beat transfers ("fire") when `valid & ready`.
- `addr` = `base_r + Σ off[d]`, modulo 2^W, formed only from registers. There is no combinational path from any input to any output.
- On fire, dim 0 increments: `idx[0]+1`, `off[0]+stride[0]`.
- When `idx[d]==count_r[d]-1`, dim d wraps:
  - `idx[d]` and `off[d]` go to 0;
  - a carry goes to dim d+1.
- `last_dim[d]` = AND over k≤d of (`idx[k]==count_r[k]-1`).
- `last` = `last_dim[DIM-1] & valid`.
- Fire with `last` -> IDLE. `done` pulses for 1 cycle.
- `stop` in RUN -> IDLE next cycle with a `done` pulse.
  - If fire coincides with `stop`, that beat counts as transferred.
  - `stop` in IDLE is ignored.
- `start` during RUN is ignored. Descriptor inputs may change freely after the start cycle.
- All arithmetic is unsigned modulo 2^W. Address wrap-around is legal and silent.
- Total beats = Π max(count[d],1). The product is not computed in hardware.

## Timing
- Reset (`rst_n`=0 at a clock edge) values:
  - `valid`, `last`, `last_dim`, `busy`, `done` = 0;
  - `addr` = 0 (base_r and offsets cleared);
  - `stall_cnt` = 0.
- Reset mid-sequence aborts immediately. No `done` pulse is produced.
- `start` at edge t -> `valid`=1 and `addr`=base from cycle t+1.
- Throughput is one beat per cycle while `ready`=1.
- With `ready`=0, `addr`, `last` and `last_dim` are held stable.
- The final fire at edge t gives `valid`=0, `busy`=0 and `done`=1 during cycle t+1.
- `start` sampled during the `done` cycle is honoured (state is IDLE), giving back-to-back sequences with a 1-cycle gap.

## Configuration
- `AGU_ND_STALL_CNT_EN` defined:
  - `stall_cnt` port exists;
  - it increments every cycle with `valid & ~ready`, saturating at 2^W-1;
  - it clears on accepted `start`.
- Macro undefined: port and logic are absent. All other behaviour is identical.

## Structure
- Package `agu_pkg` holds:
  - state enum (`AGU_IDLE`, `AGU_RUN`);
  - default `W`/`DIM` localparams;
  - a typedef for the packed descriptor arrays.
- Sub-module `agu_dim`, instantiated `DIM` times:
  - holds one index counter and one offset accumulator;
  - inputs: `clr`, `inc`, `stride`, `count`;
  - outputs: `is_last`, `carry`, `off`.
- The top level holds the FSM, `base_r`, the offset adder tree and the optional stall counter.

## Test plan
- Basic 2-D sequence:
  - stimulus: DIM=2, base=0x100, count={2,3} (dim1,dim0), stride={0x10,1}, ready=1;
  - response: addr 0x100, 0x101, 0x102, 0x110, 0x111, 0x112;
  - response: `last_dim[0]` on beats 3 and 6; `last` only on beat 6; `done` the cycle after.
- Backpressure:
  - stimulus: same run, ready=0 for 4 cycles at beat 2;
  - response: addr holds at 0x101;
  - response: with the macro defined, `stall_cnt`=4 at the end.
- Zero count:
  - stimulus: count={0,0};
  - response: exactly one beat, addr=base, `last`=1.
- Stop:
  - stimulus: `stop` asserted together with fire of beat 2;
  - response: 2 beats transferred, `valid`=0 and `done`=1 next cycle;
  - response: a following `start` with base=0x200 yields addr 0x200.
- Address wrap:
  - stimulus: base=0xFFFFFFFF, count={1,2}, stride={0,1};
  - response: addr 0xFFFFFFFF then 0x00000000.
- Reset and ignored start:
  - stimulus: `rst_n`=0 on beat 3 of a run;
  - response: all outputs return to reset values next cycle, no `done` pulse;
  - stimulus: `start` during RUN;
  - response: ignored, sequence unchanged.
